// File: rtl/register_status_file.sv
// Architectural register file with per-register busy bit and rename tag (newest in-flight ROB producer).
// Latency: lookups are combinational; commit/dispatch updates land at the next posedge when rdy=1.
// Backpressure: none internal; rdy=0 freezes all state, and lookups forward through the ROB when not ready.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), clear (ROB flush)
//   commit_*   : retiring ROB head writes reg value, frees the rename if its tag is still newest
//   dep_*      : dispatch records a new producer tag for dep_rd
//   rs1/rs2    : source lookups -> rsN_ready / rsN_value / rsN_dep, need_rob_idN to the ROB
//   rob_valueN_ready / rob_valueN : ROB forwarded operand for the queried tag
module register_status_file #(
    parameter int ROB_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clear,
    input  logic                commit_valid,
    input  logic [4:0]          commit_rd,
    input  logic [31:0]         commit_val,
    input  logic [ROB_BITS-1:0] commit_rob_id,
    input  logic                dep_valid,
    input  logic [4:0]          dep_rd,
    input  logic [ROB_BITS-1:0] dep_rob_id,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    output logic                rs1_ready,
    output logic                rs2_ready,
    output logic [31:0]         rs1_value,
    output logic [31:0]         rs2_value,
    output logic [ROB_BITS-1:0] rs1_dep,
    output logic [ROB_BITS-1:0] rs2_dep,
    output logic [ROB_BITS-1:0] need_rob_id1,
    output logic [ROB_BITS-1:0] need_rob_id2,
    input  logic                rob_value1_ready,
    input  logic                rob_value2_ready,
    input  logic [31:0]         rob_value1,
    input  logic [31:0]         rob_value2
);

    typedef struct packed {
        logic                ready;
        logic [31:0]         value;
        logic [ROB_BITS-1:0] dep;
        logic [ROB_BITS-1:0] need;
    } lookup_t;

    logic [31:0]         r_reg [32];
    logic [31:0]         r_busy;
    logic [ROB_BITS-1:0] r_tag [32];

    logic    w_commit_en;
    logic    w_dep_en;
    lookup_t w_lk1;
    lookup_t w_lk2;

    // x0 is never written, so it stays zero / not busy / tag 0 from reset onward.
    assign w_commit_en = rdy && commit_valid && (commit_rd != 5'd0);
    assign w_dep_en    = rdy && dep_valid && (dep_rd != 5'd0) && !clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_reg[i] <= '0;
                r_tag[i] <= '0;
            end
            r_busy <= '0;
        end else if (rdy) begin
            if (w_commit_en) begin
                r_reg[commit_rd] <= commit_val;
                // Only the newest producer may free the rename; an older one retiring leaves it busy.
                if (r_busy[commit_rd] && (r_tag[commit_rd] == commit_rob_id))
                    r_busy[commit_rd] <= 1'b0;
            end
            // Placed after the commit so a same-cycle flush or re-rename overrides the release.
            if (clear) begin
                r_busy <= '0;
            end else if (w_dep_en) begin
                r_busy[dep_rd] <= 1'b1;
                r_tag[dep_rd]  <= dep_rob_id;
            end
        end
    end

    // Lookup sees pre-update state; a matching commit this cycle is bypassed straight through.
    function automatic lookup_t do_lookup(input logic [4:0]  idx,
                                          input logic        rob_rdy,
                                          input logic [31:0] rob_val);
        lookup_t res;
        res.need  = r_tag[idx];
        res.ready = 1'b1;
        res.value = '0;
        res.dep   = '0;
        if (idx == 5'd0) begin
            res.value = '0;
        end else if (!r_busy[idx]) begin
            res.value = r_reg[idx];
        end else begin
            res.dep = r_tag[idx];
            if (commit_valid && (commit_rd == idx) && (commit_rob_id == r_tag[idx])) begin
                res.value = commit_val;
            end else begin
                res.ready = rob_rdy;
                res.value = rob_val;
            end
        end
        return res;
    endfunction

    always_comb begin
        w_lk1 = do_lookup(rs1, rob_value1_ready, rob_value1);
        w_lk2 = do_lookup(rs2, rob_value2_ready, rob_value2);
    end

    assign rs1_ready    = w_lk1.ready;
    assign rs1_value    = w_lk1.value;
    assign rs1_dep      = w_lk1.dep;
    assign need_rob_id1 = w_lk1.need;
    assign rs2_ready    = w_lk2.ready;
    assign rs2_value    = w_lk2.value;
    assign rs2_dep      = w_lk2.dep;
    assign need_rob_id2 = w_lk2.need;

endmodule
